mux_nx1_rr: RTL

- Parametrised, registered N:1 channel multiplexer with a valid/ready handshake on every input channel and on the output.
- Next generation of the team's 2:1 combinational mux.
- Two selection modes:
  - manual: the `sel` port picks the channel;
  - round-robin: automatic fair scanning across channels.
- Sits between multiple producer blocks and a single shared consumer datapath.

---
 rtl/mux_nx1_rr.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mux_nx1_rr.sv
// mux_nx1_rr: registered N:1 channel multiplexer with valid/ready on every
// input channel and on the output. Two selection modes:
//   mode = 0 : manual, `sel` picks the channel
//   mode = 1 : round-robin, fair scan starting at an internal pointer
//
// Ports:
//   clk        - system clock, all state updates on the rising edge
//   rst        - synchronous active-high reset
//   din        - packed channel data, channel i at [i*WIDTH +: WIDTH]
//   din_valid  - per-channel valid
//   din_ready  - per-channel accept strobe (combinational)
//   mode       - 0 = manual select, 1 = round-robin
//   sel        - channel index used in manual mode
//   dout       - registered output word
//   dout_ch    - index of the channel that supplied dout
//   dout_valid - dout holds a word
//   dout_par   - even parity of dout (only with MUX_NX1_PARITY_EN)
//   dout_ready - downstream accepts dout
//
// Optional feature: define MUX_NX1_PARITY_EN to add the dout_par output.

module mux_nx1_rr #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [CHANNELS-1:0]       din_valid,
    output logic [CHANNELS-1:0]       din_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          dout,
    output logic [SEL_W-1:0]          dout_ch,
    output logic                      dout_valid,
`ifdef MUX_NX1_PARITY_EN
    output logic                      dout_par,
`endif
    input  logic                      dout_ready
);

    logic [WIDTH-1:0] dout_q, dout_d;
    logic [SEL_W-1:0] dout_ch_q, dout_ch_d;
    logic             dout_valid_q, dout_valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             can_load;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic             load_en;
    logic [WIDTH-1:0] load_word;
    int unsigned      rr_idx;
    logic [SEL_W-1:0] rr_sel;

    // Output stage is free, or is being drained this cycle.
    assign can_load = !dout_valid_q || dout_ready;

    // Grant: at most one channel. The round-robin scan keeps the first hit
    // starting at ptr_q, wrapping past CHANNELS-1 back to 0.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        rr_idx    = 0;
        rr_sel    = '0;
        if (!mode) begin
            if (32'(sel) < CHANNELS) begin
                if (din_valid[sel]) begin
                    grant_vld = 1'b1;
                    grant_idx = sel;
                end
            end
        end else begin
            for (int k = 0; k < int'(CHANNELS); k++) begin
                rr_idx = 32'(ptr_q) + 32'(k);
                if (rr_idx >= CHANNELS) begin
                    rr_idx = rr_idx - CHANNELS;
                end
                rr_sel = SEL_W'(rr_idx);
                if (!grant_vld && din_valid[rr_sel]) begin
                    grant_vld = 1'b1;
                    grant_idx = rr_sel;
                end
            end
        end
    end

    // Ready never looks at the channel's own ready, only at valid and state.
    assign load_en   = !rst && can_load && grant_vld;
    assign din_ready = load_en ? (CHANNELS'(1) << grant_idx) : '0;
    assign load_word = din[grant_idx*WIDTH +: WIDTH];

    always_comb begin
        dout_d       = dout_q;
        dout_ch_d    = dout_ch_q;
        dout_valid_d = dout_valid_q;
        ptr_d        = ptr_q;
        if (load_en) begin
            dout_d       = load_word;
            dout_ch_d    = grant_idx;
            dout_valid_d = 1'b1;
            // Only round-robin transfers move the pointer past the winner.
            if (mode) begin
                ptr_d = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
            end
        end else if (dout_ready) begin
            // Drained with nothing to replace it; data and channel hold.
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_ch_q    <= '0;
            dout_valid_q <= 1'b0;
            ptr_q        <= '0;
        end else begin
            dout_q       <= dout_d;
            dout_ch_q    <= dout_ch_d;
            dout_valid_q <= dout_valid_d;
            ptr_q        <= ptr_d;
        end
    end

    assign dout       = dout_q;
    assign dout_ch    = dout_ch_q;
    assign dout_valid = dout_valid_q;

`ifdef MUX_NX1_PARITY_EN
    logic dout_par_q, dout_par_d;

    always_comb begin
        dout_par_d = dout_par_q;
        if (load_en) begin
            dout_par_d = ^load_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_par_q <= 1'b0;
        end else begin
            dout_par_q <= dout_par_d;
        end
    end

    assign dout_par = dout_par_q;
`endif

endmodule
